seq_detect_prog: RTL and testbench

//   Runtime-programmable serial bit-pattern detector: Moore-style, bit-serial input.

---
 rtl/seq_detect_pkg.sv | 24 ++
 rtl/sat_counter.sv | 23 ++
 rtl/seq_detect_prog.sv | 88 ++++++++
 tb/tb_seq_detect_prog.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

    // Widest pattern the mask helper can describe; MAX_LEN must not exceed it.
    localparam int MASK_W = 32;

    localparam int                DEF_RST_LEN     = 4;
    localparam logic [MASK_W-1:0] DEF_RST_PATTERN = 32'b1101;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Ones in the low 'len' bit positions, zeros above.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment yields one.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable Moore bit-pattern detector with overlap control and a saturating match count.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter int                 RST_LEN     = DEF_RST_LEN,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [MAX_LEN-1:0]          cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
    input  logic                        cfg_overlap,
    input  logic                        din_valid,
    input  logic                        din,
    input  logic                        count_clr,
    output logic                        dout,
    output logic [CNT_W-1:0]            match_count,
    output logic                        cfg_err
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] nhist;
    logic [LEN_W-1:0]   nfill;
    logic               accept;
    logic               hit;
    logic               cfg_legal;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept    = 1'b0;
        hit       = 1'b0;
        nhist     = {hist[MAX_LEN-2:0], din};
        nfill     = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        if (din_valid && !cfg_we) begin
            accept = 1'b1;
            hit    = !cfg_err && (nfill >= len_q) &&
                     (((MASK_W'(nhist) ^ MASK_W'(pattern_q)) & len_mask(int'(len_q))) == '0);
        end
    end

    // NOTE: hist and fill are reset along with the config so stale bits can never complete a match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= 1'b1;
            cfg_err   <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            dout      <= 1'b0;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cfg_err   <= !cfg_legal;
            hist      <= '0;
            fill      <= '0;
            dout      <= 1'b0;
        end else if (accept) begin
            hist <= nhist;
            // Non-overlapping mode discards the matched bits by emptying the window.
            fill <= (hit && !overlap_q) ? '0 : nfill;
            dout <= hit;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_count (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (count_clr),
        .count(match_count)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboarded random/directed bench for seq_detect_prog against a bit-queue reference model.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic       count_clr = 1'b0;

    logic        dout, dout2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;
    logic        cfg_err, cfg_err2;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
        .din(din), .count_clr(count_clr), .dout(dout),
        .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
        .din(din), .count_clr(count_clr), .dout(dout2),
        .match_count(match_count2), .cfg_err(cfg_err2)
    );

    typedef struct packed {
        logic        dout;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: the received bits since the last clear, plus the configuration.
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_err;
    bit         m_dout;
    int         m_cnt;
    int         m_cnt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat  = 8'b1101;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_err  = 1'b0;
        m_bits.delete();
        m_dout = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // The newest m_len received bits, oldest first, must read the pattern from bit m_len-1 down to 0.
    function automatic bit model_match();
        int s;
        s = m_bits.size();
        if (m_err || s < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_bits[s - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cycle(input logic we, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic v, input logic d, input logic clr);
        bit   hit;
        exp_t e;
        @(negedge clk);
        cfg_we      = we;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        din_valid   = v;
        din         = d;
        count_clr   = clr;
        hit = 1'b0;
        if (we) begin
            m_pat  = pat;
            m_len  = int'(len);
            m_ovl  = ovl;
            m_err  = (len == 0) || (int'(len) > MAX_LEN);
            m_bits.delete();
            m_dout = 1'b0;
        end else if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            hit    = model_match();
            m_dout = hit;
            if (hit && !m_ovl) m_bits.delete();
        end
        if (clr) begin
            m_cnt  = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        e.dout = m_dout;
        e.cnt  = 16'(m_cnt);
        e.cnt2 = 2'(m_cnt2);
        e.err  = m_err;
        sb.push_back(e);
    endtask

    task automatic send(input logic d);
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cycle(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_stream(input logic [7:0] bits, input int n, input int max_gap);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
            repeat ($urandom_range(0, max_gap)) idle();
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dout", 32'(dout), 32'(e.dout));
                check("match_count", 32'(match_count), 32'(e.cnt));
                check("cfg_err", 32'(cfg_err), 32'(e.err));
                check("dout_w2", 32'(dout2), 32'(e.dout));
                check("match_count_w2", 32'(match_count2), 32'(e.cnt2));
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_count", 32'(match_count), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Default pattern 1101, then a trailing 0 drops dout.
        send_stream(8'b1101, 4, 0);
        send(1'b0);

        // 101 with and without overlap.
        cfg(8'b101, 4'd3, 1'b1);
        send_stream(8'b10101, 5, 0);
        cfg(8'b101, 4'd3, 1'b0);
        send_stream(8'b10101, 5, 0);

        // Default pattern again with idle gaps; dout must hold through them.
        cfg(8'b1101, 4'd4, 1'b1);
        for (int r = 0; r < 3; r++) begin
            send_stream(8'b1101, 4, 3);
            repeat (3) idle();
        end

        // Config write collides with a valid bit: the bit is lost.
        send_stream(8'b110, 3, 0);
        cycle(1'b1, 8'b1101, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        send_stream(8'b1101, 4, 0);

        // Illegal lengths disable detection until a legal write.
        cfg(8'b1, 4'd0, 1'b1);
        send_stream(8'b11011111, 8, 1);
        cfg(8'hff, 4'd9, 1'b1);
        send_stream(8'b11111111, 8, 0);
        cfg(8'b11, 4'd2, 1'b1);
        send_stream(8'b0111, 4, 0);

        // Counter clear, saturation of the narrow counter, clear coincident with a hit.
        cfg(8'b1, 4'd1, 1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) send(1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b1);

        // Reset mid-stream discards the partial match.
        cfg(8'b1101, 4'd4, 1'b0);
        send_stream(8'b110, 3, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_dout", 32'(dout), 32'd0);
        check("midreset_count", 32'(match_count), 32'd0);
        check("midreset_err", 32'(cfg_err), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        send(1'b1);
        send_stream(8'b1101, 4, 0);

        // Random traffic with occasional reconfiguration, short patterns favoured.
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                int          s;
                logic [3:0]  l;
                s = $urandom_range(0, 19);
                if (s == 0)      l = 4'd0;
                else if (s == 1) l = 4'($urandom_range(9, 15));
                else             l = 4'($urandom_range(1, (s < 12) ? 3 : 8));
                cycle(1'b1, 8'($urandom), l, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                cycle(1'b0, 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 49) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
